// File: rtl/instrument_fetch_pkg.sv
// Shared types and constants for the instrument sample fetch arbiter.
package instrument_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    localparam int ADDR_W         = 24;
    localparam int DATA_W         = 16;
    localparam int TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/instrument_fetch_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping. The pointer itself is owned by the parent.
module rr_arbiter #(
    parameter int NUM_INST = 8,
    parameter int IDX_W    = $clog2(NUM_INST)
) (
    input  logic [NUM_INST-1:0] req_i,
    input  logic [IDX_W-1:0]    ptr_i,
    output logic [NUM_INST-1:0] grant_o,
    output logic [IDX_W-1:0]    grant_idx_o,
    output logic                any_grant_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest hit to ptr_i wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        sum         = '0;
        idx         = '0;
        for (int k = NUM_INST - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (IDX_W + 1)'(k);
            if (sum >= (IDX_W + 1)'(NUM_INST)) begin
                sum = sum - (IDX_W + 1)'(NUM_INST);
            end
            idx = sum[IDX_W-1:0];
            if (req_i[idx]) begin
                grant_idx_o = idx;
                any_grant_o = 1'b1;
            end
        end
        if (any_grant_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/instrument_fetch_arbiter.sv
// Memory-side responder for per-instrument sample address channels.
// Grants one instrument per DRAM read (round-robin, once per sample period),
// buffers returned samples and presents them to the mixer on sample_tick.
// Optional macro FETCH_TIMEOUT_EN: abandon a fetch after TIMEOUT_CYCLES
// cycles in REQ/WAIT without completion.
module instrument_fetch_arbiter #(
    parameter int NUM_INST = 8,
    parameter int ADDR_W   = instrument_fetch_pkg::ADDR_W,
    parameter int DATA_W   = instrument_fetch_pkg::DATA_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [NUM_INST*ADDR_W-1:0]   inst_addr,
    input  logic [NUM_INST-1:0]          inst_addr_valid,
    output logic [NUM_INST-1:0]          inst_addr_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic                         mem_req_valid,
    input  logic                         mem_req_ready,
    input  logic [DATA_W-1:0]            mem_rd_data,
    input  logic                         mem_rd_valid,
    output logic [NUM_INST*DATA_W-1:0]   sample_out,
    output logic                         sample_out_valid
);
    import instrument_fetch_pkg::*;

    localparam int IDX_W = $clog2(NUM_INST);

    fetch_state_t                       state_q, state_d;
    logic [IDX_W-1:0]                   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]                   grant_idx_q, grant_idx_d;
    logic [NUM_INST-1:0]                served_q, served_d;
    logic [NUM_INST-1:0]                fresh_q, fresh_d;
    logic [NUM_INST-1:0][DATA_W-1:0]    buf_q, buf_d;
    logic [NUM_INST-1:0][DATA_W-1:0]    sout_q, sout_d;
    logic                               sout_vld_q, sout_vld_d;
    logic [NUM_INST-1:0]                ready_q, ready_d;
    logic [ADDR_W-1:0]                  mem_addr_q, mem_addr_d;
    logic                               req_vld_q, req_vld_d;

    logic [NUM_INST-1:0][ADDR_W-1:0]    addr_vec;
    logic [NUM_INST-1:0]                arb_req;
    logic [NUM_INST-1:0]                arb_grant;
    logic [IDX_W-1:0]                   arb_idx;
    logic                               arb_any;

`ifdef FETCH_TIMEOUT_EN
    logic [15:0]                        tmo_cnt_q, tmo_cnt_d;
`endif

    assign addr_vec = inst_addr;
    assign arb_req  = inst_addr_valid & ~served_q;

    rr_arbiter #(
        .NUM_INST (NUM_INST),
        .IDX_W    (IDX_W)
    ) u_rr_arbiter (
        .req_i       (arb_req),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_grant_o (arb_any)
    );

    // Next-state: fetch FSM, per-period bookkeeping and tick snapshot.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        served_d    = served_q;
        fresh_d     = fresh_q;
        buf_d       = buf_q;
        sout_d      = sout_q;
        sout_vld_d  = 1'b0;
        ready_d     = '0;
        mem_addr_d  = mem_addr_q;
        req_vld_d   = req_vld_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d   = (state_q == IDLE) ? '0 : tmo_cnt_q + 16'd1;
`endif
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    ready_d     = arb_grant;
                    mem_addr_d  = addr_vec[arb_idx];
                    served_d    = served_q | arb_grant;
                    grant_idx_d = arb_idx;
                    rr_ptr_d    = (arb_idx == IDX_W'(NUM_INST - 1)) ? '0 : arb_idx + 1'b1;
                    req_vld_d   = 1'b1;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    req_vld_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (mem_rd_valid) begin
                    buf_d[grant_idx_q]   = mem_rd_data;
                    fresh_d[grant_idx_q] = 1'b1;
                    state_d              = IDLE;
                end
            end
            default: begin
                req_vld_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
`ifdef FETCH_TIMEOUT_EN
        // Give up on a fetch that has not completed; the channel stays served.
        if (state_q != IDLE && !(state_q == WAIT && mem_rd_valid) &&
            tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
            req_vld_d = 1'b0;
            state_d   = IDLE;
        end
`endif
        // Snapshot includes a response landing this cycle, then opens a new period.
        if (sample_tick) begin
            for (int i = 0; i < NUM_INST; i++) begin
                sout_d[i] = fresh_d[i] ? buf_d[i] : '0;
            end
            sout_vld_d = 1'b1;
            served_d   = '0;
            fresh_d    = '0;
        end
    end

    // State registers; reset abandons any in-flight fetch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_idx_q <= '0;
            served_q    <= '0;
            fresh_q     <= '0;
            buf_q       <= '0;
            sout_q      <= '0;
            sout_vld_q  <= 1'b0;
            ready_q     <= '0;
            mem_addr_q  <= '0;
            req_vld_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            served_q    <= served_d;
            fresh_q     <= fresh_d;
            buf_q       <= buf_d;
            sout_q      <= sout_d;
            sout_vld_q  <= sout_vld_d;
            ready_q     <= ready_d;
            mem_addr_q  <= mem_addr_d;
            req_vld_q   <= req_vld_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign inst_addr_ready  = ready_q;
    assign mem_addr         = mem_addr_q;
    assign mem_req_valid    = req_vld_q;
    assign sample_out       = sout_q;
    assign sample_out_valid = sout_vld_q;

endmodule

// File: tb/tb_instrument_fetch_arbiter.sv
// Self-checking bench for instrument_fetch_arbiter: directed scenarios plus
// randomized rounds checked against a transaction-level round-robin model.
module tb_instrument_fetch_arbiter;

    localparam int N  = 8;
    localparam int AW = 24;
    localparam int DW = 16;

    logic            clk;
    logic            rst;
    logic            sample_tick;
    logic [N*AW-1:0] inst_addr;
    logic [N-1:0]    inst_addr_valid;
    logic [N-1:0]    inst_addr_ready;
    logic [AW-1:0]   mem_addr;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic [DW-1:0]   mem_rd_data;
    logic            mem_rd_valid;
    logic [N*DW-1:0] sample_out;
    logic            sample_out_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model state: next round-robin start, per-period sample store.
    int            m_ptr;
    bit [N-1:0]    m_fresh;
    logic [DW-1:0] m_val [N];

    instrument_fetch_arbiter #(.NUM_INST(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .sample_tick      (sample_tick),
        .inst_addr        (inst_addr),
        .inst_addr_valid  (inst_addr_valid),
        .inst_addr_ready  (inst_addr_ready),
        .mem_addr         (mem_addr),
        .mem_req_valid    (mem_req_valid),
        .mem_req_ready    (mem_req_ready),
        .mem_rd_data      (mem_rd_data),
        .mem_rd_valid     (mem_rd_valid),
        .sample_out       (sample_out),
        .sample_out_valid (sample_out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] elig, input int ptr);
        for (int k = 0; k < N; k++) if (elig[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] exp_vec();
        logic [N*DW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) if (m_fresh[i]) v[i*DW +: DW] = m_val[i];
        return v;
    endfunction

    task automatic idle_inputs();
        sample_tick = 1'b0; inst_addr_valid = '0; mem_req_ready = 1'b0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0; step(); step(); rst = 1'b1; step();
        m_ptr = 0; m_fresh = '0;
    endtask

    task automatic set_addr(input int ch, input logic [AW-1:0] a);
        inst_addr[ch*AW +: AW] = a;
    endtask

    // Waits (bounded) for the next accept pulse; ch=-1 if none arrives.
    task automatic wait_grant(output int ch, output int cnt, output logic [AW-1:0] a);
        ch = -1; cnt = 0; a = '0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (inst_addr_ready != '0) begin
                cnt = $countones(inst_addr_ready);
                a   = mem_addr;
                for (int i = N - 1; i >= 0; i--) if (inst_addr_ready[i]) ch = i;
                return;
            end
        end
    endtask

    // Acts as DRAM from a REQ cycle: accept after req_lat, answer rd_lat later.
    task automatic finish_fetch(input int req_lat, input int rd_lat, input logic [DW-1:0] d,
                                output logic [N-1:0] rdy_next);
        mem_req_ready = 1'b0;
        rdy_next = '0;
        for (int c = 0; c < req_lat; c++) begin
            step();
            if (c == 0) rdy_next = inst_addr_ready;
        end
        mem_req_ready = 1'b1;
        step();
        if (req_lat == 0) rdy_next = inst_addr_ready;
        mem_req_ready = 1'b0;
        for (int c = 1; c < rd_lat; c++) step();
        mem_rd_data = d; mem_rd_valid = 1'b1;
        step();
        mem_rd_valid = 1'b0;
    endtask

    task automatic do_tick(output logic [N*DW-1:0] exp);
        exp = exp_vec();
        sample_tick = 1'b1; step(); sample_tick = 1'b0;
        m_fresh = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0; inst_addr_valid = '1; sample_tick = 1'b1; mem_rd_valid = 1'b1;
        mem_req_ready = 1'b1;
        step(); step();
        checks++; if (inst_addr_ready !== '0) begin failures++; $display("FAIL reset_ready got=%h exp=0", inst_addr_ready); end
        checks++; if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", mem_req_valid); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (sample_out !== '0) begin failures++; $display("FAIL reset_sample_out got=%h exp=0", sample_out); end
        checks++; if (sample_out_valid !== 1'b0) begin failures++; $display("FAIL reset_sample_valid got=%b exp=0", sample_out_valid); end
        idle_inputs();
        rst = 1'b1; step();
        m_ptr = 0; m_fresh = '0;
    endtask

    task automatic test_single();
        int ch, cnt; logic [AW-1:0] a; logic [N*DW-1:0] exp;
        set_addr(2, 24'h000100); inst_addr_valid = 8'b0000_0100;
        wait_grant(ch, cnt, a);
        checks++; if (ch !== 2 || cnt !== 1) begin failures++; $display("FAIL single_grant got ch=%0d cnt=%0d exp ch=2 cnt=1", ch, cnt); end
        checks++; if (a !== 24'h000100 || mem_req_valid !== 1'b1) begin failures++; $display("FAIL single_mem_addr got=%h vld=%b exp=000100 vld=1", a, mem_req_valid); end
        inst_addr_valid = '0; m_ptr = 3;
        mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
        checks++; if (inst_addr_ready !== '0 || mem_req_valid !== 1'b0) begin failures++; $display("FAIL single_pulse got rdy=%h vld=%b exp 0/0", inst_addr_ready, mem_req_valid); end
        step();
        mem_rd_data = 16'h1234; mem_rd_valid = 1'b1; step(); mem_rd_valid = 1'b0;
        m_val[2] = 16'h1234; m_fresh[2] = 1'b1;
        do_tick(exp);
        checks++; if (sample_out !== exp || sample_out_valid !== 1'b1) begin failures++; $display("FAIL single_sample got=%h vld=%b exp=%h vld=1", sample_out, sample_out_valid, exp); end
        step();
        checks++; if (sample_out_valid !== 1'b0 || sample_out !== exp) begin failures++; $display("FAIL single_hold got=%h vld=%b exp=%h vld=0", sample_out, sample_out_valid, exp); end
    endtask

    task automatic test_rr_order();
        int ch, cnt, g; logic [AW-1:0] a; logic [N-1:0] served, rn; logic [N*DW-1:0] exp;
        logic [DW-1:0] d;
        do_reset();
        for (int i = 0; i < N; i++) set_addr(i, AW'(32'h1000 * (i + 1)));
        served = '0;
        inst_addr_valid = 8'b0010_1001;
        for (int r = 0; r < 5; r++) begin
            if (r == 3) inst_addr_valid = 8'b1010_1011;
            g = rr_pick(inst_addr_valid & ~served, m_ptr);
            wait_grant(ch, cnt, a);
            checks++; if (ch !== g || cnt !== 1) begin failures++; $display("FAIL rr_order_%0d got ch=%0d cnt=%0d exp ch=%0d cnt=1", r, ch, cnt, g); end
            checks++; if (a !== AW'(32'h1000 * (g + 1))) begin failures++; $display("FAIL rr_addr_%0d got=%h exp=%h", r, a, AW'(32'h1000 * (g + 1))); end
            d = DW'($urandom);
            finish_fetch(1, 1, d, rn);
            checks++; if (rn !== '0) begin failures++; $display("FAIL rr_pulse_%0d got=%h exp=0", r, rn); end
            if (g >= 0) begin served[g] = 1'b1; m_val[g] = d; m_fresh[g] = 1'b1; m_ptr = (g + 1) % N; end
        end
        inst_addr_valid = '0;
        do_tick(exp);
        checks++; if (sample_out !== exp) begin failures++; $display("FAIL rr_sample got=%h exp=%h", sample_out, exp); end
    endtask

    task automatic test_no_regrant();
        int ch, cnt, pulses; logic [AW-1:0] a; logic [N-1:0] rn; logic [N*DW-1:0] exp;
        set_addr(1, 24'hABCDE0); inst_addr_valid = 8'b0000_0010;
        wait_grant(ch, cnt, a);
        checks++; if (ch !== 1) begin failures++; $display("FAIL noregrant_first got=%0d exp=1", ch); end
        finish_fetch(0, 3, 16'h0101, rn);
        m_val[1] = 16'h0101; m_fresh[1] = 1'b1; m_ptr = 2;
        pulses = 0;
        for (int c = 0; c < 10; c++) begin step(); if (inst_addr_ready != '0) pulses++; end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL noregrant_same_period got=%0d pulses exp=0", pulses); end
        do_tick(exp);
        checks++; if (sample_out !== exp) begin failures++; $display("FAIL noregrant_sample got=%h exp=%h", sample_out, exp); end
        wait_grant(ch, cnt, a);
        checks++; if (ch !== 1) begin failures++; $display("FAIL noregrant_next_period got=%0d exp=1", ch); end
        finish_fetch(0, 1, 16'h0202, rn);
        m_val[1] = 16'h0202; m_fresh[1] = 1'b1; m_ptr = 2;
        inst_addr_valid = '0;
        do_tick(exp);
        checks++; if (sample_out !== exp) begin failures++; $display("FAIL noregrant_sample2 got=%h exp=%h", sample_out, exp); end
    endtask

    task automatic test_stall();
        int ch, cnt, g, bad; logic [AW-1:0] a, orig; logic [N-1:0] rn; logic [N*DW-1:0] exp;
        set_addr(3, 24'h333333); set_addr(6, 24'h666666);
        inst_addr_valid = 8'b0100_1000;
        g = rr_pick(inst_addr_valid, m_ptr);
        wait_grant(ch, cnt, a);
        checks++; if (ch !== g) begin failures++; $display("FAIL stall_grant got=%0d exp=%0d", ch, g); end
        orig = (g == 3) ? 24'h333333 : 24'h666666;
        if (ch >= 0) set_addr(ch, ~orig);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (mem_req_valid !== 1'b1 || mem_addr !== orig || inst_addr_ready !== '0) begin
                failures++; bad++;
                if (bad <= 3) $display("FAIL stall_hold_%0d got vld=%b addr=%h rdy=%h exp vld=1 addr=%h rdy=0", c, mem_req_valid, mem_addr, inst_addr_ready, orig);
            end
        end
        finish_fetch(0, 2, 16'h5A5A, rn);
        m_val[g] = 16'h5A5A; m_fresh[g] = 1'b1; m_ptr = (g + 1) % N;
        g = rr_pick(inst_addr_valid & ~(8'b1 << ch), m_ptr);
        wait_grant(ch, cnt, a);
        checks++; if (ch !== g) begin failures++; $display("FAIL stall_second got=%0d exp=%0d", ch, g); end
        finish_fetch(2, 1, 16'hA5A5, rn);
        m_val[g] = 16'hA5A5; m_fresh[g] = 1'b1; m_ptr = (g + 1) % N;
        inst_addr_valid = '0;
        do_tick(exp);
        checks++; if (sample_out !== exp) begin failures++; $display("FAIL stall_sample got=%h exp=%h", sample_out, exp); end
    endtask

    task automatic test_tick_rd();
        int ch, cnt; logic [AW-1:0] a; logic [N*DW-1:0] exp;
        set_addr(4, 24'h044444); inst_addr_valid = 8'b0001_0000;
        wait_grant(ch, cnt, a);
        checks++; if (ch !== 4) begin failures++; $display("FAIL tickrd_grant got=%0d exp=4", ch); end
        inst_addr_valid = '0; m_ptr = 5;
        mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0;
        step();
        m_val[4] = 16'h7FFF; m_fresh[4] = 1'b1;
        exp = exp_vec();
        mem_rd_data = 16'h7FFF; mem_rd_valid = 1'b1; sample_tick = 1'b1;
        step();
        mem_rd_valid = 1'b0; sample_tick = 1'b0; m_fresh = '0;
        checks++; if (sample_out[4*DW +: DW] !== 16'h7FFF || sample_out !== exp) begin failures++; $display("FAIL tickrd_same_cycle got=%h exp=%h", sample_out, exp); end
        checks++; if (sample_out_valid !== 1'b1) begin failures++; $display("FAIL tickrd_valid got=%b exp=1", sample_out_valid); end
        step(); step();
        do_tick(exp);
        checks++; if (sample_out[4*DW +: DW] !== 16'h0000 || sample_out !== exp) begin failures++; $display("FAIL tickrd_silence got=%h exp=%h", sample_out, exp); end
    endtask

    task automatic test_tick_grant();
        int ch, cnt; logic [AW-1:0] a; logic [N-1:0] rn; logic [N*DW-1:0] exp;
        set_addr(6, 24'h060606);
        exp = exp_vec();
        inst_addr_valid = 8'b0100_0000; sample_tick = 1'b1;
        step();
        sample_tick = 1'b0; m_fresh = '0;
        checks++; if (inst_addr_ready !== 8'b0100_0000) begin failures++; $display("FAIL tickgrant_grant got=%h exp=40", inst_addr_ready); end
        checks++; if (sample_out_valid !== 1'b1 || sample_out !== exp) begin failures++; $display("FAIL tickgrant_sample got=%h vld=%b exp=%h vld=1", sample_out, sample_out_valid, exp); end
        finish_fetch(0, 1, 16'h1111, rn);
        m_val[6] = 16'h1111; m_fresh[6] = 1'b1; m_ptr = 7;
        wait_grant(ch, cnt, a);
        checks++; if (ch !== 6) begin failures++; $display("FAIL tickgrant_regrant got=%0d exp=6", ch); end
        finish_fetch(1, 2, 16'h2222, rn);
        m_val[6] = 16'h2222; m_fresh[6] = 1'b1;
        inst_addr_valid = '0;
        do_tick(exp);
        checks++; if (sample_out !== exp) begin failures++; $display("FAIL tickgrant_final got=%h exp=%h", sample_out, exp); end
    endtask

    task automatic test_random();
        int ch, cnt, g, n; logic [AW-1:0] a; logic [N-1:0] served, rn; logic [N*DW-1:0] exp;
        logic [AW-1:0] addrs [N]; logic [DW-1:0] d;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin addrs[i] = AW'($urandom); set_addr(i, addrs[i]); end
            inst_addr_valid = N'($urandom_range(1, (1 << N) - 1));
            served = '0;
            n = $countones(inst_addr_valid);
            for (int k = 0; k < n; k++) begin
                g = rr_pick(inst_addr_valid & ~served, m_ptr);
                wait_grant(ch, cnt, a);
                checks++;
                if (ch !== g || cnt !== 1 || (g >= 0 && a !== addrs[g])) begin
                    failures++; $display("FAIL random_%0d_%0d got ch=%0d cnt=%0d addr=%h exp ch=%0d", r, k, ch, cnt, a, g);
                end
                d = DW'($urandom);
                finish_fetch($urandom_range(0, 3), $urandom_range(1, 4), d, rn);
                if (g >= 0) begin served[g] = 1'b1; m_val[g] = d; m_fresh[g] = 1'b1; m_ptr = (g + 1) % N; end
            end
            inst_addr_valid = '0;
            step();
            do_tick(exp);
            checks++; if (sample_out !== exp || sample_out_valid !== 1'b1) begin failures++; $display("FAIL random_sample_%0d got=%h exp=%h", r, sample_out, exp); end
        end
    endtask

    task automatic test_reset_mid();
        int ch, cnt; logic [AW-1:0] a; logic [N*DW-1:0] exp;
        set_addr(0, 24'h0F0F0F); inst_addr_valid = 8'b0000_0001;
        wait_grant(ch, cnt, a);
        checks++; if (ch < 0) begin failures++; $display("FAIL resetmid_grant got=%0d exp>=0", ch); end
        mem_req_ready = 1'b1; step(); mem_req_ready = 1'b0; step();
        inst_addr_valid = '0;
        rst = 1'b0; step();
        checks++; if (sample_out !== '0 || mem_addr !== '0) begin failures++; $display("FAIL resetmid_in_reset got out=%h addr=%h exp 0", sample_out, mem_addr); end
        rst = 1'b1; step();
        m_ptr = 0; m_fresh = '0;
        mem_rd_data = 16'hBEEF; mem_rd_valid = 1'b1; step(); mem_rd_valid = 1'b0;
        step();
        checks++;
        if (inst_addr_ready !== '0 || mem_req_valid !== 1'b0 || mem_addr !== '0 || sample_out !== '0 || sample_out_valid !== 1'b0) begin
            failures++; $display("FAIL resetmid_stray got rdy=%h vld=%b addr=%h out=%h ovld=%b exp all 0", inst_addr_ready, mem_req_valid, mem_addr, sample_out, sample_out_valid);
        end
        do_tick(exp);
        checks++; if (sample_out !== exp || sample_out_valid !== 1'b1) begin failures++; $display("FAIL resetmid_tick got=%h exp=%h", sample_out, exp); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        int ch, cnt, hi; logic [AW-1:0] a; logic [N-1:0] rn; logic [N*DW-1:0] exp;
        do_reset();
        set_addr(2, 24'h222222); set_addr(5, 24'h555555);
        inst_addr_valid = 8'b0000_0100;
        wait_grant(ch, cnt, a);
        checks++; if (ch !== 2) begin failures++; $display("FAIL timeout_grant got=%0d exp=2", ch); end
        hi = 1;
        while (mem_req_valid === 1'b1 && hi < 5000) begin step(); if (mem_req_valid === 1'b1) hi++; end
        checks++; if (hi !== 4096) begin failures++; $display("FAIL timeout_cycles got=%0d exp=4096", hi); end
        inst_addr_valid = 8'b0010_0100;
        wait_grant(ch, cnt, a);
        checks++; if (ch !== 5) begin failures++; $display("FAIL timeout_next got=%0d exp=5", ch); end
        finish_fetch(0, 1, 16'h5555, rn);
        m_val[5] = 16'h5555; m_fresh[5] = 1'b1;
        inst_addr_valid = '0;
        do_tick(exp);
        checks++; if (sample_out !== exp) begin failures++; $display("FAIL timeout_sample got=%h exp=%h", sample_out, exp); end
    endtask
`endif

    initial begin
        inst_addr = '0;
        rst = 1'b0;
        idle_inputs();
        m_ptr = 0; m_fresh = '0;
        for (int i = 0; i < N; i++) m_val[i] = '0;
        test_reset();
        test_single();
        test_rr_order();
        test_no_regrant();
        test_stall();
        test_tick_rd();
        test_tick_grant();
        test_random();
        test_reset_mid();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
